// File: rtl/matrix_column_scanner_pkg.sv
// Shared types and constants for the 5x7 LED matrix column scanner.
package matrix_pkg;

   localparam int NUM_COLS = 5;
   localparam int NUM_ROWS = 7;
   localparam int IDX_W    = 3;

   typedef logic [NUM_ROWS-1:0] col_pattern_t;
   typedef col_pattern_t [NUM_COLS-1:0] frame_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      DRIVE = 2'd2
   } scan_state_t;

   localparam logic [NUM_COLS-1:0] COL_SEL_OFF = 5'b11111;
   localparam logic [IDX_W-1:0]    LAST_COL    = 3'd4;

   // Active-low one-cold column select for a column index; unknown indices select nothing.
   function automatic logic [NUM_COLS-1:0] col_sel_for(input logic [IDX_W-1:0] idx);
      logic [NUM_COLS-1:0] sel;
      case (idx)
         3'd0:    sel = 5'b11110;
         3'd1:    sel = 5'b11101;
         3'd2:    sel = 5'b11011;
         3'd3:    sel = 5'b10111;
         3'd4:    sel = 5'b01111;
         default: sel = COL_SEL_OFF;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/matrix_column_scanner_scan_timer.sv
// Per-state slot counter. Counts cycles spent in the current scanner state and
// flags the last cycle of a blank phase and of a drive phase. The FSM clears it
// on every state change, so it never runs past SCAN_DIV-1.
module scan_timer #(
   parameter int SCAN_DIV     = 50000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   output logic blank_end,
   output logic slot_end
);

   localparam int CNT_W = $clog2(SCAN_DIV);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(SCAN_DIV - BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(SCAN_DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: clear on request, otherwise increment with a hard ceiling.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Counter register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign blank_end = (cnt_q == BLANK_LAST);
   assign slot_end  = (cnt_q == DRIVE_LAST);

endmodule

// File: rtl/matrix_column_scanner.sv
// Multiplexes five 7-bit column patterns onto a 5x7 LED matrix, one column at a
// time, with a blank gap before each column. New patterns land in a shadow
// buffer and are copied to the displayed buffer only at the start of a frame.
module matrix_column_scanner
   import matrix_pkg::*;
#(
   parameter int SCAN_DIV     = 50000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                enable,
   input  logic                load,
   input  logic [NUM_ROWS-1:0] col1_in,
   input  logic [NUM_ROWS-1:0] col2_in,
   input  logic [NUM_ROWS-1:0] col3_in,
   input  logic [NUM_ROWS-1:0] col4_in,
   input  logic [NUM_ROWS-1:0] col5_in,
   output logic [NUM_ROWS-1:0] row_out,
   output logic [NUM_COLS-1:0] col_sel,
   output logic                frame_done,
   output logic                pending
);

   scan_state_t         state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   frame_t              shadow_q, shadow_d;
   frame_t              active_q, active_d;
   logic                pending_q, pending_d;
   col_pattern_t        row_q, row_d;
   logic [NUM_COLS-1:0] col_sel_q, col_sel_d;
   logic                frame_done_q, frame_done_d;

   frame_t col_in_s;
   logic   swap_s;
   logic   timer_clear_s;
   logic   blank_end_s;
   logic   slot_end_s;

   assign col_in_s = {col5_in, col4_in, col3_in, col2_in, col1_in};

   scan_timer #(
      .SCAN_DIV     (SCAN_DIV),
      .BLANK_CYCLES (BLANK_CYCLES)
   ) u_scan_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (timer_clear_s),
      .blank_end (blank_end_s),
      .slot_end  (slot_end_s)
   );

   // Scan FSM next state: column stepping, frame wrap and the buffer swap point.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      swap_s       = 1'b0;
      frame_done_d = 1'b0;
      if (!enable) begin
         state_d = IDLE;
         idx_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = BLANK;
               idx_d   = '0;
               swap_s  = 1'b1;
            end
            BLANK: begin
               if (blank_end_s) begin
                  state_d = DRIVE;
               end else begin
                  state_d = BLANK;
               end
            end
            DRIVE: begin
               if (slot_end_s) begin
                  state_d = BLANK;
                  if (idx_q == LAST_COL) begin
                     idx_d        = '0;
                     swap_s       = 1'b1;
                     frame_done_d = 1'b1;
                  end else begin
                     idx_d = idx_q + 3'd1;
                  end
               end else begin
                  state_d = DRIVE;
               end
            end
            default: begin
               state_d = IDLE;
               idx_d   = '0;
            end
         endcase
      end
      timer_clear_s = (state_d != state_q) || (state_q == IDLE);
   end

   // Double buffer: shadow captures loads; active changes only at the swap,
   // taking the load inputs directly when a load coincides with the swap.
   always_comb begin
      shadow_d  = shadow_q;
      active_d  = active_q;
      pending_d = pending_q;
      if (load) begin
         shadow_d = col_in_s;
      end else begin
         shadow_d = shadow_q;
      end
      if (swap_s) begin
         active_d  = load ? col_in_s : shadow_q;
         pending_d = 1'b0;
      end else if (load) begin
         pending_d = 1'b1;
      end else begin
         pending_d = pending_q;
      end
   end

   // Output drive computed from the upcoming state so the pins update with it.
   always_comb begin
      row_d     = '0;
      col_sel_d = COL_SEL_OFF;
      if (state_d == DRIVE) begin
         row_d     = active_d[idx_d];
         col_sel_d = col_sel_for(idx_d);
      end else begin
         row_d     = '0;
         col_sel_d = COL_SEL_OFF;
      end
   end

   // State, buffer and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         shadow_q     <= '0;
         active_q     <= '0;
         pending_q    <= 1'b0;
         row_q        <= '0;
         col_sel_q    <= COL_SEL_OFF;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         shadow_q     <= shadow_d;
         active_q     <= active_d;
         pending_q    <= pending_d;
         row_q        <= row_d;
         col_sel_q    <= col_sel_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign row_out    = row_q;
   assign col_sel    = col_sel_q;
   assign frame_done = frame_done_q;
   assign pending    = pending_q;

endmodule

// File: tb/tb_matrix_column_scanner.sv
// Bench for matrix_column_scanner with SCAN_DIV=8, BLANK_CYCLES=2.
// A frame-timeline model predicts every cycle's outputs into a queue that is
// compared each negedge; directed table entries and sequences add hand checks.
module tb_matrix_column_scanner;

   localparam int SCAN_DIV     = 8;
   localparam int BLANK_CYCLES = 2;
   localparam int FRAME        = 5 * SCAN_DIV;

   logic       clk = 1'b0;
   logic       rst_n, enable, load;
   logic [6:0] col_in [5];
   logic [6:0] row_out;
   logic [4:0] col_sel;
   logic       frame_done, pending;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [6:0] row;
      logic [4:0] sel;
      logic       fd;
      logic       pend;
   } obs_t;
   obs_t sb_q [$];

   typedef struct {
      logic [34:0] pat;
      int          mode;
      logic [6:0]  exp_old;
      logic [6:0]  exp_col0;
   } vec_t;
   vec_t tbl [3];

   logic [6:0] m_act [5];
   logic [6:0] m_sh  [5];
   logic       m_pend;
   logic       m_run;
   int         m_t;

   matrix_column_scanner #(.SCAN_DIV(SCAN_DIV), .BLANK_CYCLES(BLANK_CYCLES)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .load(load),
      .col1_in(col_in[0]), .col2_in(col_in[1]), .col3_in(col_in[2]),
      .col4_in(col_in[3]), .col5_in(col_in[4]),
      .row_out(row_out), .col_sel(col_sel), .frame_done(frame_done), .pending(pending)
   );

   always #5 clk = ~clk;

   // Predict the outputs visible after this edge from time since the frame start.
   task automatic model_step();
      obs_t e;
      logic sw;
      int   slot;
      e  = '0;
      sw = 1'b0;
      if (!rst_n) begin
         m_run = 1'b0; m_t = 0; m_pend = 1'b0;
         for (int i = 0; i < 5; i++) begin m_act[i] = 7'h00; m_sh[i] = 7'h00; end
      end else if (!enable) begin
         m_run = 1'b0; m_t = 0;
         if (load) begin
            for (int i = 0; i < 5; i++) m_sh[i] = col_in[i];
            m_pend = 1'b1;
         end
      end else begin
         if (!m_run) begin m_run = 1'b1; m_t = 0; sw = 1'b1; end
         else if (m_t == FRAME - 1) begin m_t = 0; sw = 1'b1; e.fd = 1'b1; end
         else m_t++;
         if (sw) begin
            for (int i = 0; i < 5; i++) m_act[i] = load ? col_in[i] : m_sh[i];
            m_pend = 1'b0;
         end else if (load) begin
            m_pend = 1'b1;
         end
         if (load) for (int i = 0; i < 5; i++) m_sh[i] = col_in[i];
      end
      if (m_run && (m_t % SCAN_DIV) >= BLANK_CYCLES) begin
         slot  = m_t / SCAN_DIV;
         e.row = m_act[slot];
         e.sel = ~(5'b00001 << slot);
      end else begin
         e.row = 7'h00;
         e.sel = 5'b11111;
      end
      e.pend = m_pend;
      sb_q.push_back(e);
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // Scoreboard: compare each cycle's prediction against the DUT at negedge.
   initial forever begin
      obs_t e;
      @(negedge clk);
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         checks++;
         if ({row_out, col_sel, frame_done, pending} !== e) begin
            errors++;
            $display("FAIL sb t=%0t got row=%h sel=%b fd=%b pend=%b want row=%h sel=%b fd=%b pend=%b",
                     $time, row_out, col_sel, frame_done, pending, e.row, e.sel, e.fd, e.pend);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", name, act, exp);
      end
   endtask

   task automatic set_cols(input logic [34:0] p);
      for (int i = 0; i < 5; i++) col_in[i] = p[i*7 +: 7];
   endtask

   task automatic wait_sel(input logic [4:0] v, input int budget, input string name);
      int n;
      n = 0;
      do begin @(negedge clk); n++; end while (col_sel !== v && n < budget);
      if (col_sel !== v) begin
         checks++; errors++;
         $display("FAIL %s timeout got sel=%b want sel=%b", name, col_sel, v);
      end
   endtask

   task automatic wait_fd(input int budget, input string name);
      int n;
      n = 0;
      do begin @(negedge clk); n++; end while (frame_done !== 1'b1 && n < budget);
      if (frame_done !== 1'b1) begin
         checks++; errors++;
         $display("FAIL %s timeout got fd=%b want fd=1", name, frame_done);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout got=running want=finished");
      $fatal(1);
   end

   initial begin
      int n;
      logic [4:0] s;
      tbl[0] = '{{7'h77, 7'h47, 7'h35, 7'h1D, 7'h3C}, 0, 7'h00, 7'h3C};
      tbl[1] = '{{7'h47, 7'h77, 7'h5D, 7'h5C, 7'h0D}, 1, 7'h47, 7'h0D};
      tbl[2] = '{{7'h40, 7'h01, 7'h7F, 7'h15, 7'h2A}, 2, 7'h00, 7'h2A};

      rst_n = 1'b0; enable = 1'b0; load = 1'b0;
      set_cols(35'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_row", row_out, 7'h00);
      chk("rst_sel", col_sel, 5'b11111);
      chk("rst_fd", frame_done, 1'b0);
      chk("rst_pend", pending, 1'b0);
      @(posedge clk); #1 rst_n = 1'b1;

      // Startup with empty buffers: two blank cycles, then the column walk.
      @(posedge clk); #1 enable = 1'b1;
      @(posedge clk);
      @(negedge clk); chk("start_blank0", col_sel, 5'b11111);
      @(negedge clk); chk("start_blank1", col_sel, 5'b11111);
      @(negedge clk); chk("start_col0", col_sel, 5'b11110);
      chk("start_row", row_out, 7'h00);
      for (int c = 0; c < 5; c++) begin
         s = ~(5'b00001 << c);
         n = 0;
         while (col_sel === s && n < 20) begin n++; @(negedge clk); end
         chk($sformatf("drive_len_c%0d", c), n, 6);
         n = 0;
         while (col_sel === 5'b11111 && n < 20) begin n++; @(negedge clk); end
         chk($sformatf("blank_len_c%0d", c), n, 2);
      end
      wait_fd(50, "fd_first");
      n = 0;
      do begin @(negedge clk); n++; end while (frame_done !== 1'b1 && n < 60);
      chk("frame_period", n, FRAME);

      // Table-driven loads: in IDLE, mid-frame, and exactly on the swap edge.
      for (int k = 0; k < 3; k++) begin
         case (tbl[k].mode)
            0: begin
               @(posedge clk); #1 enable = 1'b0;
               @(posedge clk); #1 load = 1'b1; set_cols(tbl[k].pat);
               @(posedge clk); #1 load = 1'b0;
               @(negedge clk);
               chk("idle_pend", pending, 1'b1);
               chk("idle_sel", col_sel, 5'b11111);
               @(posedge clk); #1 enable = 1'b1;
               wait_sel(5'b11110, 20, "idle_col0");
               chk("idle_row0", row_out, tbl[k].exp_col0);
               chk("idle_pend_clr", pending, 1'b0);
            end
            1: begin
               wait_sel(5'b11011, 60, "mid_col2");
               @(posedge clk); #1 load = 1'b1; set_cols(tbl[k].pat);
               @(posedge clk); #1 load = 1'b0;
               @(negedge clk); chk("mid_pend", pending, 1'b1);
               wait_sel(5'b10111, 60, "mid_col3");
               chk("mid_old_row", row_out, tbl[k].exp_old);
               wait_fd(60, "mid_fd");
               chk("mid_pend_at_fd", pending, 1'b0);
               wait_sel(5'b11110, 20, "mid_col0");
               chk("mid_row0", row_out, tbl[k].exp_col0);
            end
            2: begin
               wait_sel(5'b01111, 60, "swap_col4");
               repeat (5) @(posedge clk);
               #1 load = 1'b1; set_cols(tbl[k].pat);
               @(posedge clk); #1 load = 1'b0;
               @(negedge clk);
               chk("swap_fd", frame_done, 1'b1);
               chk("swap_pend", pending, 1'b0);
               wait_sel(5'b11110, 20, "swap_col0");
               chk("swap_row0", row_out, tbl[k].exp_col0);
               chk("swap_pend_after", pending, 1'b0);
            end
            default: chk("bad_mode", tbl[k].mode, 0);
         endcase
      end

      // Drop enable during column 3 drive, then restart from column 0.
      wait_sel(5'b10111, 60, "dis_col3");
      @(posedge clk); #1 enable = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("dis_sel", col_sel, 5'b11111);
      chk("dis_row", row_out, 7'h00);
      @(posedge clk); #1 enable = 1'b1;
      @(posedge clk);
      @(negedge clk); chk("re_blank0", col_sel, 5'b11111);
      @(negedge clk); chk("re_blank1", col_sel, 5'b11111);
      @(negedge clk); chk("re_col0", col_sel, 5'b11110);
      chk("re_row0", row_out, 7'h2A);

      // Reset mid-frame with a pending load discards everything.
      wait_sel(5'b11101, 60, "rst_col1");
      @(posedge clk); #1 load = 1'b1; set_cols({7'h55, 7'h44, 7'h33, 7'h22, 7'h11});
      @(posedge clk); #1 load = 1'b0;
      @(negedge clk); chk("pre_rst_pend", pending, 1'b1);
      @(posedge clk); #1 rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("mid_rst_row", row_out, 7'h00);
      chk("mid_rst_sel", col_sel, 5'b11111);
      chk("mid_rst_fd", frame_done, 1'b0);
      chk("mid_rst_pend", pending, 1'b0);
      @(posedge clk); #1 rst_n = 1'b1;
      wait_sel(5'b11110, 20, "post_rst_col0");
      chk("post_rst_row0", row_out, 7'h00);
      wait_sel(5'b11101, 20, "post_rst_col1");
      chk("post_rst_row1", row_out, 7'h00);

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/matrix_column_scanner.md
# matrix_column_scanner

Downstream of `game_selection`, this block takes the five 7-bit column patterns of the selected game and multiplexes them onto the physical 5×7 LED matrix. Only one column is driven at a time.
- Each column slot has a programmable scan rate and a blanking interval to suppress ghosting.
- Pattern updates are double-buffered: a newly loaded game shows only from the start of the next frame, never in the middle of one.

## Interface
Parameters:
- `SCAN_DIV`, default 50000: clock cycles per column slot (blank + drive); must be > `BLANK_CYCLES`.
- `BLANK_CYCLES`, default 16: cycles of all-off output at the start of each column slot; must be ≥ 1.

Ports:
- `clk` in 1: system clock; the block has a single clock domain.
- `rst_n` in 1: reset, synchronous, active-low.
- `enable` in 1: scanning runs while high.
- `load` in 1: single-cycle pulse; captures `col1_in`..`col5_in` into the shadow buffer.
- `col1_in`..`col5_in` in 7 each: column patterns from game selection; bit i is row i.
- `row_out` out 7: row drive, active-high.
- `col_sel` out 5: column select, active-low, at most one bit low.
- `frame_done` out 1: one-cycle pulse when a frame completes.
- `pending` out 1: shadow buffer holds data not yet shown.

## Operation
- Buffers:
  - Shadow: five 7-bit registers, written when `load` is sampled high; `pending` is then set.
  - Active: five 7-bit registers, the only source for `row_out`.
- Swap: active <= shadow and `pending` <= 0, on the edge that enters BLANK for column 0. That edge is either leaving IDLE or leaving DRIVE of column 4.
- If `load` is sampled high on the swap edge, active takes the `colN_in` values directly (bypass) and `pending` ends at 0.
- FSM states: IDLE, BLANK, DRIVE.
  - IDLE: `row_out`=0, `col_sel`=5'b11111, column index = 0. `enable`=1 → BLANK (column 0, swap applies).
  - BLANK: outputs off for exactly `BLANK_CYCLES` cycles → DRIVE.
  - DRIVE: `col_sel` bit[idx]=0, `row_out`=active[idx], for exactly `SCAN_DIV`−`BLANK_CYCLES` cycles. Then → BLANK with idx+1; after idx 4, idx wraps to 0, `frame_done` pulses and the swap applies.
- `enable` sampled low in any state → IDLE on that edge; outputs off next cycle, index cleared. Shadow, active and `pending` are retained.
- `load` is accepted in every state, including IDLE and mid-frame. A mid-frame load never alters the active buffer before the next swap.
- Back-to-back loads before a swap: last one wins, `pending` stays 1.
- Slot counter: width `$clog2(SCAN_DIV)`. It resets to 0 on every state transition and never exceeds `SCAN_DIV`−1.

## Timing
- All outputs are registered; no combinational path from any input to any output.
- Reset values (`rst_n` sampled low): state IDLE, `row_out`=7'b0, `col_sel`=5'b11111, `frame_done`=0, `pending`=0, both buffers all zero, counter 0, index 0.
- Startup: if `enable` is sampled high at edge E, BLANK occupies edges E..E+`BLANK_CYCLES`−1. The column 0 drive is visible after edge E+`BLANK_CYCLES`.
- Frame period is 5×`SCAN_DIV` cycles. `frame_done` is high for exactly the one cycle following the swap edge.
- Load-to-display latency:
  - Minimum: `BLANK_CYCLES`+1 cycles, when the load is on the swap edge.
  - Maximum: 5×`SCAN_DIV`+`BLANK_CYCLES` cycles while scanning.
- Reset mid-operation takes priority over `enable` and `load`; the next cycle shows all reset values.

## Structure
- Package `matrix_pkg`:
  - Constants: `NUM_COLS`=5, `NUM_ROWS`=7.
  - Type: `col_pattern_t` (logic [6:0]).
  - State enum `scan_state_t` {IDLE, BLANK, DRIVE}.
  - Reset constant `COL_SEL_OFF`=5'b11111.
- Sub-module `scan_timer`: parameterised slot counter that emits `blank_end` and `slot_end` strobes. It is cleared by the FSM.
- Buffers, FSM and output registers live in the top module.

## Test plan
Use `SCAN_DIV`=8 and `BLANK_CYCLES`=2 throughout.
- Reset, then `enable`=1 with no load → outputs off for 2 cycles, then `col_sel` walks 11110, 11101, 11011, 10111, 01111. Each column is driven for 6 cycles after 2 blank cycles. `row_out`=0 throughout. `frame_done` pulses every 40 cycles.
- Load col1..col5 = 7'h3C, 7'h1D, 7'h35, 7'h47, 7'h77 while in IDLE → `pending`=1. After enable, column 0 drives `row_out`=7'h3C and `pending`=0.
- Mid-frame load (during column 2) of 7'h0D, 7'h5C, 7'h5D, 7'h77, 7'h47 → the current frame stays unchanged. The next column 0 shows 7'h0D. `pending` clears on the same edge that raises `frame_done`.
- Load on the exact swap edge → the new data appears in the following column 0 drive and `pending` stays 0.
- Deassert `enable` during DRIVE of column 3 → next cycle `col_sel`=11111 and `row_out`=0. Re-enable restarts at column 0 with 2 blank cycles.
- Assert `rst_n`=0 mid-frame with `pending`=1 → next cycle all reset values; a subsequent enable drives all-zero rows.
